// File: rtl/arbiter_pkg.sv
// Shared types and default parameters for the round-robin burst arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int ARB_N_DEF   = 4;
   localparam int ARB_TMO_DEF = 256;

endpackage : arbiter_pkg

// File: rtl/arbiter_fx_priority.sv
// Fixed-priority picker: one-hot of the lowest-index set request bit.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
//
// Ports:
//   i_req   - request vector
//   o_gnt   - one-hot grant of lowest set index, all-zero when no request
module arbiter_fx_priority #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_gnt
);

   logic found;

   always_comb begin
      o_gnt = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (i_req[i] && !found) begin
            o_gnt[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule : arbiter_fx_priority

// File: rtl/arbiter_rr_burst.sv
// Round-robin arbiter holding a one-hot grant for a whole multi-beat burst.
// Latency: grant registered, one clock after request (no bubble between bursts).
// Backpressure: burst ends only on i_ack with owner's i_last; optional timeout forces release.
//
// Ports:
//   clk, rstn    - rising-edge clock, asynchronous active-low reset
//   i_req        - per-requester request
//   i_last       - per-requester last-beat flag (only the owner's bit, only with i_ack)
//   i_ack        - shared resource took one beat this cycle
//   o_grant      - registered one-hot grant
//   o_grant_vld  - any grant active
//   o_grant_id   - binary index of owner, 0 when idle
//   o_tmo        - one-cycle pulse on the cycle a stalled burst is forcibly released
//
// Build option: define ARB_TIMEOUT_EN to enable the stall-timeout counter
// (TMO_CYC consecutive un-acked grant cycles). Without it o_tmo is tied low.
module arbiter_rr_burst
   import arbiter_pkg::*;
#(
   parameter int N       = ARB_N_DEF,
   parameter int TMO_CYC = ARB_TMO_DEF
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [N-1:0]         i_req,
   input  logic [N-1:0]         i_last,
   input  logic                 i_ack,
   output logic [N-1:0]         o_grant,
   output logic                 o_grant_vld,
   output logic [$clog2(N)-1:0] o_grant_id,
   output logic                 o_tmo
);

   localparam int IW = $clog2(N);

   arb_state_t      state_q, state_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [IW-1:0]   ptr_q, ptr_d;

   logic [IW-1:0]   owner_id;
   logic [IW-1:0]   nxt_ptr;
   logic [IW-1:0]   arb_ptr;
   logic            tmo;
   logic            rel;
   logic [N-1:0]    mask;
   logic [N-1:0]    gnt_masked;
   logic [N-1:0]    gnt_plain;
   logic [N-1:0]    win;

   // Owner index straight from the one-hot grant register.
   always_comb begin
      owner_id = '0;
      for (int i = 0; i < N; i++) begin
         if (grant_q[i]) owner_id = IW'(i);
      end
   end

   assign nxt_ptr = (owner_id == IW'(N - 1)) ? '0 : owner_id + IW'(1);

   // A burst ends on the owner's acked last beat, or on a stall timeout.
   assign rel = (state_q == GRANT) && ((i_ack && |(i_last & grant_q)) || tmo);

   // On release the just-advanced pointer is used immediately so the next
   // grant lands on the following edge and the old owner ranks last.
   assign arb_ptr = rel ? nxt_ptr : ptr_q;

   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i >= int'(arb_ptr));
      end
   end

   arbiter_fx_priority #(.N(N)) u_pri_masked (
      .i_req (i_req & mask),
      .o_gnt (gnt_masked)
   );

   arbiter_fx_priority #(.N(N)) u_pri_plain (
      .i_req (i_req),
      .o_gnt (gnt_plain)
   );

   // Requesters at or above the pointer win first; otherwise wrap to the bottom.
   assign win = (|gnt_masked) ? gnt_masked : gnt_plain;

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TMO_CYC + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tmo = (state_q == GRANT) && !i_ack && (cnt_q == CW'(TMO_CYC - 1));

   // Counts consecutive un-acked grant cycles of the current burst; any
   // ack, any new grant, or idle clears it.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q != GRANT || rel || i_ack) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_tmo;

   assign unused_tmo = (TMO_CYC > 0);
   assign tmo        = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (|i_req) begin
               grant_d = win;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (rel) begin
               ptr_d = nxt_ptr;
               if (|i_req) begin
                  grant_d = win;
               end else begin
                  grant_d = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign o_grant     = grant_q;
   assign o_grant_vld = |grant_q;
   assign o_grant_id  = owner_id;
   assign o_tmo       = tmo;

endmodule : arbiter_rr_burst

// File: tb/tb_arbiter_rr_burst.sv
// Self-checking bench for arbiter_rr_burst (N=4, TMO_CYC=8).
// Directed scenarios plus randomized traffic against a rotation-based model.
// Inputs driven just after the rising edge; outputs sampled off-edge.
module tb_arbiter_rr_burst;

   localparam int N   = 4;
   localparam int TMO = 8;
`ifdef ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rstn;
   logic [N-1:0] i_req;
   logic [N-1:0] i_last;
   logic         i_ack;
   logic [N-1:0] o_grant;
   logic         o_grant_vld;
   logic [1:0]   o_grant_id;
   logic         o_tmo;

   int tests = 0;
   int fails = 0;

   // Reference model: owner (-1 = none), rotation pointer, stall count.
   int m_owner;
   int m_ptr;
   int m_cnt;

   always #5 clk = ~clk;

   arbiter_rr_burst #(.N(N), .TMO_CYC(TMO)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .i_req       (i_req),
      .i_last      (i_last),
      .i_ack       (i_ack),
      .o_grant     (o_grant),
      .o_grant_vld (o_grant_vld),
      .o_grant_id  (o_grant_id),
      .o_tmo       (o_tmo)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // First requester found walking p, p+1, ... around the ring.
   function automatic int pick(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (r[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
   endtask

   // Called at posedge+1; applies one cycle of stimulus and checks results.
   task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic a);
      bit          exp_tmo;
      logic [N-1:0] exp_g;
      i_req  = r;
      i_last = l;
      i_ack  = a;
      @(negedge clk);
      exp_tmo = TMO_EN && (m_owner >= 0) && !a && (m_cnt == TMO - 1);
      check("tmo", {31'd0, o_tmo}, {31'd0, exp_tmo});
      if (m_owner < 0) begin
         m_owner = pick(r, m_ptr);
         m_cnt   = 0;
      end else if ((a && l[m_owner]) || exp_tmo) begin
         m_ptr   = (m_owner + 1) % N;
         m_owner = pick(r, m_ptr);
         m_cnt   = 0;
      end else begin
         m_cnt = a ? 0 : m_cnt + 1;
      end
      @(posedge clk);
      #1;
      exp_g = (m_owner < 0) ? '0 : N'(1 << m_owner);
      check("grant", {28'd0, o_grant}, {28'd0, exp_g});
      check("vld", {31'd0, o_grant_vld}, {31'd0, (m_owner >= 0)});
      check("id", {30'd0, o_grant_id}, (m_owner < 0) ? 32'd0 : 32'(m_owner));
   endtask

   // Asynchronous reset from posedge+1; outputs must clear before any edge.
   task automatic do_reset();
      i_req  = '0;
      i_last = '0;
      i_ack  = 1'b0;
      rstn   = 1'b0;
      #1;
      check("rst_grant", {28'd0, o_grant}, 32'd0);
      check("rst_vld", {31'd0, o_grant_vld}, 32'd0);
      check("rst_id", {30'd0, o_grant_id}, 32'd0);
      check("rst_tmo", {31'd0, o_tmo}, 32'd0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [N-1:0] r;
      logic [N-1:0] l;
      model_reset();
      rstn   = 1'b0;
      i_req  = '0;
      i_last = '0;
      i_ack  = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // Single grant with one-cycle latency.
      cycle(4'b1010, 4'b0000, 1'b0);
      check("first_grant", {28'd0, o_grant}, 32'h2);
      check("first_id", {30'd0, o_grant_id}, 32'd1);

      // Three-beat burst by owner 1, then immediate handover to 3.
      cycle(4'b1010, 4'b0000, 1'b1);
      check("burst_b1", {28'd0, o_grant}, 32'h2);
      cycle(4'b1010, 4'b1000, 1'b1);
      check("burst_b2", {28'd0, o_grant}, 32'h2);
      cycle(4'b1010, 4'b0010, 1'b1);
      check("handover", {28'd0, o_grant}, 32'h8);

      // Full rotation with single-beat bursts.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         cycle(4'b1111, 4'b1111, 1'b1);
         check("rotate", {28'd0, o_grant}, 32'(1 << (k % N)));
      end

      // Wrap from 3 to 0, then reset mid-burst, then fresh arbitration.
      do_reset();
      cycle(4'b1000, 4'b0000, 1'b0);
      cycle(4'b1001, 4'b1000, 1'b1);
      check("wrap", {28'd0, o_grant}, 32'h1);
      cycle(4'b0100, 4'b0001, 1'b1);
      check("own2", {28'd0, o_grant}, 32'h4);
      do_reset();
      cycle(4'b0110, 4'b0000, 1'b0);
      check("post_rst", {28'd0, o_grant}, 32'h2);

      // Stalled burst: forced release with timeout, or held forever without.
      do_reset();
      cycle(4'b0001, 4'b0000, 1'b0);
      if (TMO_EN) begin
         for (int k = 0; k < TMO; k++) cycle(4'b0011, 4'b0000, 1'b0);
         check("tmo_release", {28'd0, o_grant}, 32'h2);
      end else begin
         for (int k = 0; k < 110; k++) cycle(4'b0011, 4'b0000, 1'b0);
         check("hold", {28'd0, o_grant}, 32'h1);
      end

      // Randomized traffic, with one reset in the middle.
      do_reset();
      for (int k = 0; k < 600; k++) begin
         if (k == 300) do_reset();
         r = N'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) r = '0;
         l = N'($urandom_range(0, 15));
         cycle(r, l, ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0);
         check("onehot", 32'($countones(o_grant)) <= 32'd1 ? 32'd1 : 32'd0, 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_arbiter_rr_burst

// File: doc/arbiter_rr_burst.md
ARBITER_RR_BURST -- requirements
Module: arbiter_rr_burst

Interface
REQ-001 SHALL have parameter N, default 4, number of requesters (min 2).
REQ-002 SHALL have parameter TMO_CYC, default 256, burst-timeout cycle limit (used only with ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_req  input  N  per-requester request.
REQ-006 SHALL have port i_last  input  N  per-requester last-beat flag of burst.
REQ-007 SHALL have port i_ack  input  1  shared resource accepted one beat this cycle.
REQ-008 SHALL have port o_grant  output  N  registered one-hot grant.
REQ-009 SHALL have port o_grant_vld  output  1  high when any grant active.
REQ-010 SHALL have port o_grant_id  output  $clog2(N)  binary index of owner; 0 when no grant.
REQ-011 SHALL have port o_tmo  output  1  one-cycle burst-timeout pulse.

Function
REQ-012 SHALL implement FSM with states IDLE and GRANT.
REQ-013 IDLE: any i_req bit high -> GRANT; winner's o_grant bit high on next clock edge (1-cycle latency).
REQ-014 Winner SHALL be first requesting index in order ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (round-robin).
REQ-015 GRANT: o_grant held constant until release, regardless of owner's i_req or other requesters.
REQ-016 Release SHALL occur in a cycle where i_ack=1 and i_last[owner]=1; i_last ignored when i_ack=0; i_last of non-owners ignored.
REQ-017 On release, ptr SHALL load (owner+1) mod N, wrapping N-1 -> 0.
REQ-018 On release, arbitration SHALL be evaluated in the same cycle using the updated ptr; if any i_req high, new grant on next edge (no idle bubble), else -> IDLE with o_grant=0.
REQ-019 Owner still requesting at release SHALL be arbitrated at lowest priority.
REQ-020 i_ack in IDLE SHALL be ignored.
REQ-021 o_grant SHALL never have more than one bit set; o_grant_vld = |o_grant; o_grant_id consistent with o_grant in the same cycle.

Reset
REQ-022 rstn low SHALL immediately force o_grant=0, o_grant_vld=0, o_grant_id=0, o_tmo=0, ptr=0, state=IDLE, timeout counter=0, including mid-burst.
REQ-023 First arbitration after rstn deassertion SHALL use ptr=0.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: counter counts consecutive GRANT cycles with i_ack=0, cleared on i_ack=1 and on every new grant; at TMO_CYC-th such cycle, forced release as in REQ-017/018, o_tmo=1 for that one cycle.
REQ-025 Macro ARB_TIMEOUT_EN undefined: no counter; o_tmo tied 0; grant held until REQ-016 release indefinitely.

Structure
REQ-026 Package arbiter_pkg SHALL hold state typedef (arb_state_t: IDLE, GRANT) and default parameter constants.
REQ-027 Round-robin winner SHALL use two arbiter_fx_priority instances: one on i_req masked to indices >= ptr, one on unmasked i_req; masked result selected when nonzero.

Verification (N=4, TMO_CYC=8)
REQ-028 Reset, then i_req=1010 -> next edge o_grant=0010, o_grant_id=1, o_grant_vld=1.
REQ-029 Owner 1, i_req=1010 held, three i_ack beats, i_last[1] on third -> grant 0010 for all three beats, next edge o_grant=1000 with no bubble.
REQ-030 i_req=1111 held, i_ack=1 and i_last=1111 every cycle -> grants 0001,0010,0100,1000,0001 in consecutive cycles.
REQ-031 Owner 3 released with i_req=1001 -> next grant 0001 (wrap); rstn low while o_grant=0100 -> o_grant=0000 before next edge; after reset i_req=0110 -> o_grant=0010.
REQ-032 ARB_TIMEOUT_EN defined, grant 0001, i_req=0011, i_ack=0 -> o_tmo pulse on 8th grant cycle, next edge o_grant=0010; macro undefined, same stimulus -> o_grant=0001 held 100+ cycles, o_tmo=0.
